// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch port and
// the load/store data port of a core. One read may be outstanding at a time;
// the arbiter records which port owns it and steers the returning read data
// (valid MEM_LAT cycles after the grant) back to that port.
//
// Grants are combinational: a requester sees o_*_gnt in the same cycle it
// raises its request, provided the grant slot is eligible. The slot is
// eligible when no read is outstanding, or on the return cycle of the
// outstanding read. This allows one read per cycle at MEM_LAT = 1.
//
// Optional feature (compile-time macro ARB_STARVE_GUARD_EN):
//   When defined, a saturating counter tracks eligible slots in which the
//   fetch port requested but was not granted. Once it reaches STARVE_MAX,
//   the next eligible slot goes to the fetch port even if data requests.
//   When undefined, the data port always wins and no counter exists.
//
// Parameters:
//   WIDTH      data word width
//   ADDR_W     address width (both ports)
//   MEM_LAT    cycles from accepted read to valid i_mem_rdata (>= 1)
//   STARVE_MAX denied-slot limit for the fetch port (starvation guard only)
//
// Ports:
//   i_clk, i_rst                  clock (rising edge), sync active-high reset
//   i_if_req, i_if_addr           fetch read request / address
//   o_if_gnt                      fetch request accepted this cycle
//   o_if_rvalid, o_if_rdata       fetch read data return
//   i_d_req, i_d_we               data request, 1 = write
//   i_d_addr, i_d_wdata           data address / write data
//   o_d_gnt                       data request accepted this cycle
//   o_d_rvalid, o_d_rdata         load data return
//   o_mem_req, o_mem_we           memory strobe / write enable
//   o_mem_addr, o_mem_wdata       memory address / write data
//   i_mem_rdata                   memory read data
//   o_busy                        a read is outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // instruction fetch port
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [WIDTH-1:0]  o_if_rdata,
  // load/store data port
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [WIDTH-1:0]  i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [WIDTH-1:0]  o_d_rdata,
  // memory macro
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WIDTH-1:0]  o_mem_wdata,
  input  logic [WIDTH-1:0]  i_mem_rdata,
  // status
  output logic              o_busy
);

  // Counter wide enough to hold MEM_LAT; guarded so an illegal MEM_LAT still
  // elaborates far enough to reach the error below.
  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1 (got %0d)", MEM_LAT);
  end

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be >= 1 (got %0d)", STARVE_MAX);
  end

  // ---------------------------------------------------------------------------
  // Types and state
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,   // no read outstanding
    ST_WAIT = 1'b1    // read outstanding, lat_cnt counting down
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  owner_e             owner_q,   owner_d;

  logic               return_cycle;  // outstanding read's data is on i_mem_rdata
  logic               slot_ok;       // a new grant may be issued this cycle
  logic               force_if;      // starvation guard overrides data priority
  logic               if_gnt;
  logic               d_gnt;
  logic               rd_gnt;        // a read (either port) is granted

  // ---------------------------------------------------------------------------
  // Slot eligibility
  // ---------------------------------------------------------------------------
  // Reset masks everything combinationally so no grant or rvalid can escape
  // while i_rst is high, independent of the (possibly stale) register state.
  assign return_cycle = !i_rst && (state_q == ST_WAIT) &&
                        (lat_cnt_q == CNT_W'(1));

  assign slot_ok = !i_rst && ((state_q == ST_IDLE) || return_cycle);

  // ---------------------------------------------------------------------------
  // Optional fetch starvation guard
  // ---------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

  // Only meaningful while fetch is still asking; a grant is never issued
  // to a port that is not requesting.
  assign force_if = (starve_cnt_q == SC_W'(STARVE_MAX)) && i_if_req;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt) begin
      starve_cnt_d = '0;
    end else if (slot_ok && i_if_req &&
                 (starve_cnt_q != SC_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant selection: data over fetch unless the guard forces fetch.
  // At most one grant per cycle by construction.
  // ---------------------------------------------------------------------------
  assign d_gnt  = slot_ok && i_d_req && !force_if;
  assign if_gnt = slot_ok && i_if_req && !d_gnt;
  assign rd_gnt = if_gnt || (d_gnt && !i_d_we);

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;

    case (state_q)
      ST_IDLE: begin
        // Writes complete in their grant cycle and leave the FSM idle.
        if (rd_gnt) begin
          state_d   = ST_WAIT;
          lat_cnt_d = CNT_W'(MEM_LAT);
          owner_d   = d_gnt ? OWN_D : OWN_IF;
        end
      end

      ST_WAIT: begin
        if (lat_cnt_q == CNT_W'(1)) begin
          // Return cycle: chain straight into a new read if one is granted,
          // otherwise (no grant, or a write) fall back to idle.
          if (rd_gnt) begin
            state_d   = ST_WAIT;
            lat_cnt_d = CNT_W'(MEM_LAT);
            owner_d   = d_gnt ? OWN_D : OWN_IF;
          end else begin
            state_d   = ST_IDLE;
            lat_cnt_d = '0;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        lat_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      owner_q   <= OWN_IF;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_if_gnt    = if_gnt;
  assign o_d_gnt     = d_gnt;

  // Memory side is muxed from whichever port holds the grant this cycle.
  // Fetch never writes, so write data always comes from the data port.
  assign o_mem_req   = if_gnt || d_gnt;
  assign o_mem_we    = d_gnt && i_d_we;
  assign o_mem_addr  = d_gnt ? i_d_addr : i_if_addr;
  assign o_mem_wdata = i_d_wdata;

  // Read data is a straight pass-through; rvalid qualifies it per owner.
  assign o_if_rvalid = return_cycle && (owner_q == OWN_IF);
  assign o_d_rvalid  = return_cycle && (owner_q == OWN_D);
  assign o_if_rdata  = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;

  assign o_busy      = !i_rst && (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances share one clock: index 0 runs with MEM_LAT = 1,
// index 1 with MEM_LAT = 3. Each has a small memory model that returns data
// MEM_LAT cycles after an accepted read (default contents derived from the
// address, overridden by writes). Directed stimulus checks grants inline and
// pushes expected read responses into a per-instance queue; a monitor pops
// and compares whenever an rvalid appears.
// Build with +define+ARB_STARVE_GUARD_EN to exercise the starvation guard.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          at;
  } resp_t;

  logic        clk;
  logic        mem_clr;
  int          cyc;
  int          total;
  int          bad;
  resp_t       q0[$];
  resp_t       q1[$];

  logic        rst       [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic        d_gnt     [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic        mem_req   [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  // default memory contents
  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;

    mem_port_arbiter #(
      .WIDTH(32), .ADDR_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)
    ) u_dut (
      .i_clk(clk),
      .i_rst(rst[gi]),
      .i_if_req(if_req[gi]),
      .i_if_addr(if_addr[gi]),
      .o_if_gnt(if_gnt[gi]),
      .o_if_rvalid(if_rvalid[gi]),
      .o_if_rdata(if_rdata[gi]),
      .i_d_req(d_req[gi]),
      .i_d_we(d_we[gi]),
      .i_d_addr(d_addr[gi]),
      .i_d_wdata(d_wdata[gi]),
      .o_d_gnt(d_gnt[gi]),
      .o_d_rvalid(d_rvalid[gi]),
      .o_d_rdata(d_rdata[gi]),
      .o_mem_req(mem_req[gi]),
      .o_mem_we(mem_we[gi]),
      .o_mem_addr(mem_addr[gi]),
      .o_mem_wdata(mem_wdata[gi]),
      .i_mem_rdata(mem_rdata[gi]),
      .o_busy(busy[gi])
    );

    logic        pv [LAT];
    logic [31:0] pa [LAT];
    logic [31:0] wmem [64];
    logic        wv [64];

    always @(posedge clk) begin
      pv[0] <= mem_req[gi] & ~mem_we[gi];
      pa[0] <= mem_addr[gi];
      for (int j = 1; j < LAT; j++) begin
        pv[j] <= pv[j-1];
        pa[j] <= pa[j-1];
      end
      if (mem_clr) begin
        for (int j = 0; j < 64; j++) wv[j] <= 1'b0;
      end else if (mem_req[gi] && mem_we[gi]) begin
        wmem[mem_addr[gi][7:2]] <= mem_wdata[gi];
        wv[mem_addr[gi][7:2]]   <= 1'b1;
      end
    end

    assign mem_rdata[gi] = !pv[LAT-1]            ? 32'hBAD0BAD0 :
                           wv[pa[LAT-1][7:2]]    ? wmem[pa[LAT-1][7:2]] :
                                                   dflt(pa[LAT-1]);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int k, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] dd);
    if_req[k]  = ir;
    if_addr[k] = ia;
    d_req[k]   = dr;
    d_we[k]    = dw;
    d_addr[k]  = da;
    d_wdata[k] = dd;
  endtask

  task automatic expect_rd(input int k, input bit is_d, input logic [31:0] data,
                           input int lat);
    resp_t e;
    e.is_d = is_d;
    e.data = data;
    e.at   = cyc + lat;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // one cycle: drive inputs, then check grants/busy mid-cycle
  task automatic slot(input int k, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] dd, input logic ei, input logic ed,
                      input logic eb, input string nm);
    tick();
    drv(k, ir, ia, dr, dw, da, dd);
    @(negedge clk);
    chk({nm, "_if_gnt"}, {31'd0, if_gnt[k]}, {31'd0, ei});
    chk({nm, "_d_gnt"},  {31'd0, d_gnt[k]},  {31'd0, ed});
    chk({nm, "_busy"},   {31'd0, busy[k]},   {31'd0, eb});
    $display("slot %s dut%0d cyc=%0d if_gnt=%0b d_gnt=%0b busy=%0b",
             nm, k, cyc, if_gnt[k], d_gnt[k], busy[k]);
  endtask

  task automatic chk_reset_outs(input int k, input string nm);
    chk({nm, "_if_gnt"},    {31'd0, if_gnt[k]},    32'd0);
    chk({nm, "_d_gnt"},     {31'd0, d_gnt[k]},     32'd0);
    chk({nm, "_mem_req"},   {31'd0, mem_req[k]},   32'd0);
    chk({nm, "_mem_we"},    {31'd0, mem_we[k]},    32'd0);
    chk({nm, "_busy"},      {31'd0, busy[k]},      32'd0);
    chk({nm, "_if_rvalid"}, {31'd0, if_rvalid[k]}, 32'd0);
    chk({nm, "_d_rvalid"},  {31'd0, d_rvalid[k]},  32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // response monitor
  // ---------------------------------------------------------------------------
  task automatic mon(input int k);
    resp_t       e;
    bit          isd;
    logic [31:0] dat;
    isd = d_rvalid[k];
    dat = isd ? d_rdata[k] : if_rdata[k];
    total++;
    if (if_rvalid[k] && d_rvalid[k]) begin
      bad++;
      $display("FAIL rvalid_both dut%0d cyc=%0d: got both rvalids want one", k, cyc);
      return;
    end
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      bad++;
      $display("FAIL rvalid_unexpected dut%0d cyc=%0d: got port_d=%0b data=%h want none",
               k, cyc, isd, dat);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    if (e.is_d != isd || e.data !== dat || e.at != cyc) begin
      bad++;
      $display("FAIL resp dut%0d: got port_d=%0b data=%h cyc=%0d want port_d=%0b data=%h cyc=%0d",
               k, isd, dat, cyc, e.is_d, e.data, e.at);
    end else begin
      $display("resp dut%0d port_d=%0b data=%h cyc=%0d ok", k, isd, dat, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (if_rvalid[0] || d_rvalid[0]) mon(0);
    if (if_rvalid[1] || d_rvalid[1]) mon(1);
  end

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit if_done;
    bit ei;
    total   = 0;
    bad     = 0;
    mem_clr = 1'b1;
    rst[0]  = 1'b1;
    rst[1]  = 1'b1;
    drv(0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h40, 32'h0);
    drv(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // reset with both ports requesting on dut0
    repeat (2) begin
      @(negedge clk);
      chk_reset_outs(0, "rst0");
      chk_reset_outs(1, "rst1");
    end
    tick();
    rst[0]  = 1'b0;
    rst[1]  = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    chk("rel_if_gnt", {31'd0, if_gnt[0]}, 32'd0);
    chk("rel_d_gnt",  {31'd0, d_gnt[0]},  32'd1);
    chk("rel_addr",   mem_addr[0],        32'h40);
    chk("rel_busy",   {31'd0, busy[0]},   32'd0);
    expect_rd(0, 1'b1, 32'hC0DE0040, 1);
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rel_t1");
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rel_t2");

    // fetch-only read, MEM_LAT = 1
    slot(0, 1, 32'h10, 0, 0, 0, 0, 1, 0, 0, "if_rd");
    chk("if_rd_addr", mem_addr[0], 32'h10);
    chk("if_rd_we",   {31'd0, mem_we[0]}, 32'd0);
    expect_rd(0, 1'b0, 32'hDEADBEEF, 1);
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "if_rd_t1");
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "if_rd_t2");

    // simultaneous reads, MEM_LAT = 3
    slot(1, 1, 32'h4C, 1, 0, 32'h48, 0, 0, 1, 0, "l3_t0");
    chk("l3_t0_addr", mem_addr[1], 32'h48);
    expect_rd(1, 1'b1, 32'hC0DE0048, 3);
    slot(1, 1, 32'h4C, 0, 0, 0, 0, 0, 0, 1, "l3_t1");
    slot(1, 1, 32'h4C, 0, 0, 0, 0, 0, 0, 1, "l3_t2");
    slot(1, 1, 32'h4C, 0, 0, 0, 0, 1, 0, 1, "l3_t3");
    chk("l3_t3_addr", mem_addr[1], 32'h4C);
    expect_rd(1, 1'b0, 32'hC0DE004C, 3);
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "l3_t4");
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "l3_t5");
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "l3_t6");
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "l3_t7");

    // data write then fetch read of the same address
    slot(0, 1, 32'h20, 1, 1, 32'h20, 32'h1234, 0, 1, 0, "wr");
    chk("wr_we",    {31'd0, mem_we[0]},  32'd1);
    chk("wr_req",   {31'd0, mem_req[0]}, 32'd1);
    chk("wr_addr",  mem_addr[0],         32'h20);
    chk("wr_wdata", mem_wdata[0],        32'h1234);
    slot(0, 1, 32'h20, 0, 0, 0, 0, 1, 0, 0, "wr_t1");
    chk("wr_t1_we", {31'd0, mem_we[0]}, 32'd0);
    expect_rd(0, 1'b0, 32'h00001234, 1);
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "wr_t2");
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "wr_t3");

    // reset in the middle of a MEM_LAT = 3 read
    slot(1, 1, 32'h50, 0, 0, 0, 0, 1, 0, 0, "mr_t0");
    tick();
    drv(1, 0, 0, 0, 0, 0, 0);
    rst[1] = 1'b1;
    @(negedge clk);
    chk_reset_outs(1, "mr_t1");
    tick();
    rst[1] = 1'b0;
    drv(1, 0, 0, 1, 0, 32'h54, 0);
    @(negedge clk);
    chk("mr_t2_d_gnt", {31'd0, d_gnt[1]}, 32'd1);
    chk("mr_t2_busy",  {31'd0, busy[1]},  32'd0);
    expect_rd(1, 1'b1, 32'hC0DE0054, 3);
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "mr_t3");
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "mr_t4");
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "mr_t5");
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "mr_t6");

    // continuous data reads with a pending fetch request, MEM_LAT = 1
    if_done = 1'b0;
    for (int i = 0; i < 7; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      ei = (i == 4);
`else
      ei = 1'b0;
`endif
      slot(0, !if_done, 32'h64, 1, 0, 32'h60, 0, ei, !ei, (i > 0),
           $sformatf("starve%0d", i));
      if (ei) begin
        expect_rd(0, 1'b0, 32'hC0DE0064, 1);
        if_done = 1'b1;
      end else begin
        expect_rd(0, 1'b1, 32'hC0DE0060, 1);
      end
    end
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "starve_end1");
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "starve_end2");

    // every expected response must have arrived
    repeat (4) tick();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store data port.
- Arbitrates requests, keeps one read outstanding, tracks which port owns it, and routes returning read data back to that port.
- Sits between the core datapath (instruction address/data and data-memory interfaces) and the memory macro.
- A requester stalls on its side until it sees its grant.

Parameters:
- WIDTH, 32, data word width
- ADDR_W, 32, address width, shared by both ports
- MEM_LAT, 1, cycles from an accepted read to valid i_mem_rdata; legal range >= 1
- STARVE_MAX, 4, consecutive denied cycles before the fetch port is forced a grant (optional feature only)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch read request
- i_if_addr  in  ADDR_W  fetch address
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  fetch read data valid
- o_if_rdata  out  WIDTH  fetch read data
- i_d_req  in  1  data request
- i_d_we  in  1  1 = write, 0 = read
- i_d_addr  in  ADDR_W  data address
- i_d_wdata  in  WIDTH  write data
- o_d_gnt  out  1  data request accepted this cycle
- o_d_rvalid  out  1  load data valid
- o_d_rdata  out  WIDTH  load data
- o_mem_req  out  1  memory access strobe; memory always accepts
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  WIDTH  memory write data
- i_mem_rdata  in  WIDTH  memory read data
- o_busy  out  1  a read is outstanding

Behaviour:
- Single clock, i_clk. Reset is i_rst: synchronous, active-high.
- FSM states:
  - IDLE: no outstanding read.
  - WAIT: read outstanding; lat_cnt counts down.
- Grant path is combinational:
  - o_mem_req = o_if_gnt | o_d_gnt.
  - Memory address, write data and write enable are muxed from the granted port in the same cycle.
  - At most one grant per cycle.
- Grant eligibility in a cycle:
  - state IDLE, or
  - state WAIT with lat_cnt == 1 (return cycle). This makes back-to-back reads possible: at MEM_LAT=1, one read every cycle.
- Priority: data port over fetch port when both request.
- Read granted at cycle T:
  - Register the owner (IF or D); lat_cnt <= MEM_LAT; go to WAIT.
  - At cycle T+MEM_LAT, owner's rvalid = 1 and owner's rdata = i_mem_rdata (combinational pass-through).
  - Both rvalids are 0 in all other cycles.
- lat_cnt decrements each cycle in WAIT.
  - On the return cycle: if a new read is granted, reload; otherwise go to IDLE.
  - A write granted in the return cycle also moves to IDLE.
- Write granted: completes in the grant cycle; no rvalid; state unchanged (remains IDLE). Next grant allowed at T+1.
- No grant in cycles T+1 .. T+MEM_LAT-1 after a read.
- o_busy = (state == WAIT).
- Requester rules:
  - Hold req/addr/we/wdata stable until gnt.
  - Dropping req before gnt is legal and has no side effects.
  - gnt is never asserted without req.
- o_if_rdata / o_d_rdata are don't-care when rvalid = 0; the bench checks data only with rvalid.
- Reset, while i_rst = 1 and on the following edge:
  - state IDLE, lat_cnt 0, owner IF, starve counter 0.
  - All gnt, rvalid, o_mem_req, o_mem_we and o_busy forced to 0.
- Reset mid-read: the outstanding read is abandoned and no rvalid is ever produced for it.
- MEM_LAT = 0 is illegal; flag it with an elaboration-time check.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN
- Defined:
  - starve_cnt increments (saturating at STARVE_MAX) each cycle where i_if_req = 1, the grant slot is eligible and the fetch port is not granted.
  - starve_cnt clears on a fetch grant.
  - When starve_cnt == STARVE_MAX, the next eligible slot goes to the fetch port even if i_d_req = 1.
- Undefined: strict data-over-fetch priority; no counter is synthesized.

Test Plan:
- Reset with both ports requesting, then release reset -> all outputs 0 during reset; first cycle after release grants D only.
- Fetch-only read of addr 0x10, memory returns 0xDEADBEEF, MEM_LAT=1 -> o_if_gnt at T, o_if_rvalid=1 and o_if_rdata=0xDEADBEEF at T+1, o_busy=1 at T+1 only.
- Simultaneous read requests, MEM_LAT=3 -> D granted at T; IF granted at T+3, the same cycle o_d_rvalid=1; o_if_rvalid at T+6; no grants at T+1 and T+2.
- D write addr 0x20 data 0x1234 followed by IF read -> o_mem_we=1 at T with correct addr/data, no rvalid for the write; IF granted at T+1.
- Assert i_rst at T+1 of a MEM_LAT=3 read -> no rvalid at T+3; state IDLE; a new request is granted on the first cycle after reset.
- With ARB_STARVE_GUARD_EN, STARVE_MAX=4, continuous D reads plus IF request at MEM_LAT=1 -> IF granted on the 5th eligible slot, then D resumes. Without the macro -> IF is never granted while D requests.
